// File: rtl/muntjac_fpu_normalize_from_int_seq.sv
// Iterative integer-to-float normaliser: coarse/fine left-shift loop with valid/ready handshake.
// Optional flush input is enabled by defining MUNTJAC_FPU_NORM_FLUSH_EN.
module muntjac_fpu_normalize_from_int_seq #(
  parameter int OutExpWidth = 9,
  parameter int OutSigWidth = 23,
  parameter int ShiftStep   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
`ifdef MUNTJAC_FPU_NORM_FLUSH_EN
  input  logic                          flush_i,
`endif
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_signed_i,
  input  logic                          req_dword_i,
  input  logic [63:0]                   req_int_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic                          resp_sign_o,
  output logic signed [OutExpWidth-1:0] resp_exponent_o,
  output logic [OutSigWidth-1:0]        resp_significand_o,
  output logic                          resp_sticky_o,
  output logic                          resp_is_zero_o
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        mag_q;
  logic signed [7:0]  exp_q;
  logic               sign_q;

  logic               flush;
  logic               accept;
  logic [63:0]        operand;
  logic               op_neg;
  logic [63:0]        op_mag;
  logic               mag_zero;
  logic               mag_top;
  logic               coarse_ok;
  logic               finish;

  // OR of everything below the kept significand; empty when OutSigWidth covers all 63 bits.
  function automatic logic sticky_of(input logic [63:0] m);
    logic [62:0] low;
    low = m[62:0] << OutSigWidth;
    return |low;
  endfunction

`ifdef MUNTJAC_FPU_NORM_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign accept       = req_valid_i && req_ready_o && !flush;

  assign operand = req_dword_i  ? req_int_i :
                   req_signed_i ? {{32{req_int_i[31]}}, req_int_i[31:0]} :
                                  {32'b0, req_int_i[31:0]};
  assign op_neg  = req_signed_i && operand[63];
  // -2^63 negates to itself, which is the correct unsigned magnitude.
  assign op_mag  = op_neg ? (64'd0 - operand) : operand;

  assign mag_zero  = (mag_q == 64'd0);
  assign mag_top   = mag_q[63];
  assign coarse_ok = (mag_q[63 -: ShiftStep] == '0);
  assign finish    = (state_q == NORM) && (mag_zero || mag_top) && !flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = NORM;
      NORM:    if (mag_zero || mag_top) state_d = DONE;
      DONE:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_q              <= '0;
      exp_q              <= '0;
      sign_q             <= 1'b0;
      resp_sign_o        <= 1'b0;
      resp_exponent_o    <= '0;
      resp_significand_o <= '0;
      resp_sticky_o      <= 1'b0;
      resp_is_zero_o     <= 1'b0;
    end else if (accept) begin
      mag_q  <= op_mag;
      exp_q  <= 8'sd63;
      sign_q <= op_neg;
    end else if (finish) begin
      // Outputs only change here, so they stay frozen for the whole DONE state.
      resp_sign_o        <= sign_q && !mag_zero;
      resp_exponent_o    <= mag_zero ? '0 : OutExpWidth'(exp_q);
      resp_significand_o <= mag_q[62 -: OutSigWidth];
      resp_sticky_o      <= sticky_of(mag_q);
      resp_is_zero_o     <= mag_zero;
      if (mag_zero) exp_q <= '0;
    end else if (state_q == NORM && !flush) begin
      if (coarse_ok) begin
        mag_q <= mag_q << ShiftStep;
        exp_q <= exp_q - $signed(8'(ShiftStep));
      end else begin
        mag_q <= mag_q << 1;
        exp_q <= exp_q - 8'sd1;
      end
    end
  end

endmodule

// File: tb/tb_muntjac_fpu_normalize_from_int_seq.sv
// Randomised self-checking bench for the iterative from-int normaliser against a leading-one model.
module tb_muntjac_fpu_normalize_from_int_seq;

  localparam int EW = 9;
  localparam int SW = 23;
  localparam int SS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_signed = 1'b0;
  logic          req_dword = 1'b0;
  logic [63:0]   req_int = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_sign;
  logic [EW-1:0] resp_exponent;
  logic [SW-1:0] resp_significand;
  logic          resp_sticky;
  logic          resp_is_zero;

  int total = 0;
  int bad   = 0;

  logic          e_sign;
  int            e_exp;
  logic [SW-1:0] e_sig;
  logic          e_sticky;
  logic          e_zero;
  int            e_lat;
  int            lat;

  always #5 clk = ~clk;

  muntjac_fpu_normalize_from_int_seq #(
    .OutExpWidth(EW), .OutSigWidth(SW), .ShiftStep(SS)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef MUNTJAC_FPU_NORM_FLUSH_EN
    .flush_i(flush),
`endif
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_signed_i(req_signed),
    .req_dword_i(req_dword),
    .req_int_i(req_int),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_sign_o(resp_sign),
    .resp_exponent_o(resp_exponent),
    .resp_significand_o(resp_significand),
    .resp_sticky_o(resp_sticky),
    .resp_is_zero_o(resp_is_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: find the leading one of the magnitude and slice the bits beneath it.
  task automatic model(input logic dw, input logic sg, input logic [63:0] v);
    logic [63:0] op, m, rem;
    int p;
    op = dw ? v : (sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]});
    m  = (sg && op[63]) ? 64'd0 - op : op;
    if (m == 0) begin
      e_sign = 0; e_exp = 0; e_sig = '0; e_sticky = 0; e_zero = 1; e_lat = 1;
      return;
    end
    p = 63;
    while (!m[p]) p--;
    rem = m & ~(64'd1 << p);
    e_sign = sg && op[63];
    e_exp  = p;
    e_zero = 0;
    if (p >= SW) begin
      e_sig    = SW'(rem >> (p - SW));
      e_sticky = (rem & ((64'd1 << (p - SW)) - 1)) != 0;
    end else begin
      e_sig    = SW'(rem << (SW - p));
      e_sticky = 0;
    end
    e_lat = 1 + (63 - p) / SS + (63 - p) % SS;
  endtask

  // Every cycle a result is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      chk("sign", 64'(resp_sign), 64'(e_sign));
      chk("exponent", 64'(resp_exponent), 64'(EW'(e_exp)));
      chk("significand", 64'(resp_significand), 64'(e_sig));
      chk("sticky", 64'(resp_sticky), 64'(e_sticky));
      chk("is_zero", 64'(resp_is_zero), 64'(e_zero));
      chk("ready_while_valid", 64'(req_ready), 64'd0);
    end
  end

  task automatic start_op(input logic dw, input logic sg, input logic [63:0] v);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
    model(dw, sg, v);
    req_valid = 1; req_dword = dw; req_signed = sg; req_int = v;
    @(posedge clk); #1;
    req_valid = 0; req_int = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (resp_valid) break;
    end
    chk("latency", 64'(lat), 64'(e_lat));
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk("held_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("post_hs_valid", 64'(resp_valid), 64'd0);
    chk("post_hs_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int quiet;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_outs", {resp_sign, resp_sticky, resp_is_zero, 23'(resp_exponent), 32'(resp_significand)}, 64'd0);
    @(negedge clk); rst_n = 1;

    start_op(1, 0, 64'h1);
    chk("lit1_lat", 64'(lat), 64'd15);
    chk("lit1_exp", 64'(resp_exponent), 64'd0);
    chk("lit1_sig", 64'(resp_significand), 64'd0);
    chk("lit1_sticky_sign", {resp_sticky, resp_sign}, 64'd0);
    finish_op(0);

    start_op(0, 1, 64'h1234_5678_FFFF_FFFF);
    chk("lit2_sign", 64'(resp_sign), 64'd1);
    chk("lit2_exp", 64'(resp_exponent), 64'd0);
    chk("lit2_zero", 64'(resp_is_zero), 64'd0);
    finish_op(1);

    start_op(1, 1, 64'h8000_0000_0000_0000);
    chk("lit3_lat", 64'(lat), 64'd1);
    chk("lit3_sign", 64'(resp_sign), 64'd1);
    chk("lit3_exp", 64'(resp_exponent), 64'd63);
    chk("lit3_sig_sticky", {resp_sticky, 32'(resp_significand)}, 64'd0);
    finish_op(0);

    start_op(1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit4_exp", 64'(resp_exponent), 64'd63);
    chk("lit4_sig", 64'(resp_significand), 64'h7F_FFFF);
    chk("lit4_sticky", 64'(resp_sticky), 64'd1);
    finish_op(0);

    start_op(1, 1, 64'h0);
    chk("lit5_zero", 64'(resp_is_zero), 64'd1);
    chk("lit5_sign", 64'(resp_sign), 64'd0);
    finish_op(5);

    // Asynchronous reset in the middle of a long normalisation.
    @(negedge clk);
    req_valid = 1; req_dword = 1; req_signed = 0; req_int = 64'h1;
    @(posedge clk); #1; req_valid = 0;
    repeat (5) @(posedge clk);
    #2; rst_n = 0; #1;
    chk("arst_valid", 64'(resp_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    chk("arst_outs", {resp_sign, resp_sticky, resp_is_zero, 23'(resp_exponent), 32'(resp_significand)}, 64'd0);
    @(negedge clk); rst_n = 1;

`ifdef MUNTJAC_FPU_NORM_FLUSH_EN
    @(negedge clk);
    req_valid = 1; req_dword = 1; req_signed = 0; req_int = 64'h1;
    @(posedge clk); #1; req_valid = 0;
    repeat (3) @(posedge clk);
    #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    chk("flush_ready", 64'(req_ready), 64'd1);
    quiet = 0;
    repeat (20) begin @(posedge clk); #1; if (resp_valid) quiet++; end
    chk("flush_no_resp", 64'(quiet), 64'd0);
    @(negedge clk);
    req_valid = 1; flush = 1;
    @(posedge clk); #1; req_valid = 0; flush = 0;
    chk("flush_blocks_accept", 64'(req_ready), 64'd1);
`endif

    for (int i = 0; i < 150; i++) begin
      v = {$urandom, $urandom};
      v = v >> $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) v = 64'h0;
      if ($urandom_range(0, 15) == 0) v = 64'h8000_0000_0000_0000 | v;
      start_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v);
      finish_op($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
